// File: rtl/chip_valve_sequencer_if.sv
// ---------------------------------------------------------------------------
// chip_valve_sequencer_if
// Bundles the command inputs and the valve/status outputs of the ChIP valve
// sequencer so they travel as one port.
//   master : drives start/abort/run parameters, observes valves and status
//   slave  : the sequencer side (receives commands, drives valves/status)
// Valve polarity everywhere: 1 = pressurised/closed, 0 = open.
// ---------------------------------------------------------------------------
interface chip_valve_sequencer_if;
    // command side
    logic        start;
    logic        abort;
    logic [2:0]  inlet_sel;
    logic [15:0] dur_load;
    logic [7:0]  pump_period;
    logic [15:0] pump_cycles;
    logic [15:0] dur_collect;
    // valve / status side
    logic [4:0]  inlet_ctrl;
    logic        prep_inlet_ctrl;
    logic        prep_outlet_ctrl;
    logic        stage_in_ctrl;
    logic        stage_inlet_ctrl;
    logic        bead_ctrl;
    logic        sieve_ctrl;
    logic        collect_ctrl;
    logic        pump1;
    logic        pump2;
    logic        pump3;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, abort, inlet_sel, dur_load, pump_period, pump_cycles, dur_collect,
        input  inlet_ctrl, prep_inlet_ctrl, prep_outlet_ctrl, stage_in_ctrl,
               stage_inlet_ctrl, bead_ctrl, sieve_ctrl, collect_ctrl,
               pump1, pump2, pump3, busy, done, err
    );

    modport slave (
        input  start, abort, inlet_sel, dur_load, pump_period, pump_cycles, dur_collect,
        output inlet_ctrl, prep_inlet_ctrl, prep_outlet_ctrl, stage_in_ctrl,
               stage_inlet_ctrl, bead_ctrl, sieve_ctrl, collect_ctrl,
               pump1, pump2, pump3, busy, done, err
    );
endinterface

// File: rtl/chip_valve_sequencer.sv
// ---------------------------------------------------------------------------
// chip_valve_sequencer
// Runs one ChIP microfluidic sequence per start request:
//   IDLE -> LOAD -> TRANSFER -> BEAD -> PUMP -> COLLECT -> DONE -> IDLE
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : chip_valve_sequencer_if.slave (commands in, valves/status out)
// Parameters:
//   TRANSFER_CYC : TRANSFER state length in clocks
//   BEAD_CYC     : BEAD state length in clocks
// All outputs are registered and are computed from the next state, so a
// valve change is visible on the first clock of the state that causes it.
// ---------------------------------------------------------------------------
module chip_valve_sequencer #(
    parameter int TRANSFER_CYC = 64,
    parameter int BEAD_CYC     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    chip_valve_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TRANSFER,
        S_BEAD,
        S_PUMP,
        S_COLLECT,
        S_DONE
    } state_t;

    localparam logic [15:0] TRANSFER_M1 = 16'(TRANSFER_CYC - 1);
    localparam logic [15:0] BEAD_M1     = 16'(BEAD_CYC - 1);

    // Counters are loaded with length-1 and the state exits when they hit 0;
    // a zero length is stretched to one clock.
    function automatic logic [15:0] len_m1(input logic [15:0] len);
        return (len == 16'd0) ? 16'd0 : len - 16'd1;
    endfunction

    function automatic logic sel_legal(input logic [2:0] sel);
        return (sel >= 3'd1) && (sel <= 3'd5);
    endfunction

    // {pump1,pump2,pump3} for each of the six peristaltic steps.
    function automatic logic [2:0] pump_pattern(input logic [2:0] idx);
        logic [2:0] p;
        case (idx)
            3'd0:    p = 3'b011;
            3'd1:    p = 3'b001;
            3'd2:    p = 3'b101;
            3'd3:    p = 3'b100;
            3'd4:    p = 3'b110;
            3'd5:    p = 3'b010;
            default: p = 3'b111;
        endcase
        return p;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic [2:0]  step_idx_q, step_idx_d;
    logic [23:0] steps_left_q, steps_left_d;

    logic [2:0]  sel_q, sel_d;
    logic [15:0] dur_load_q, dur_load_d;
    logic [7:0]  period_q, period_d;
    logic [15:0] cycles_q, cycles_d;
    logic [15:0] dur_collect_q, dur_collect_d;

    logic [4:0]  inlet_ctrl_q, inlet_ctrl_d;
    logic        prep_inlet_q, prep_inlet_d;
    logic        prep_outlet_q, prep_outlet_d;
    logic        stage_in_q, stage_in_d;
    logic        stage_inlet_q, stage_inlet_d;
    logic        bead_q, bead_d;
    logic        sieve_q, sieve_d;
    logic        collect_q, collect_d;
    logic [2:0]  pump_q, pump_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        step_cnt_d    = step_cnt_q;
        step_idx_d    = step_idx_q;
        steps_left_d  = steps_left_q;
        sel_d         = sel_q;
        dur_load_d    = dur_load_q;
        period_d      = period_q;
        cycles_d      = cycles_q;
        dur_collect_d = dur_collect_q;
        err_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort in the same cycle as start cancels the request entirely
                if (bus.start && !bus.abort) begin
                    if (sel_legal(bus.inlet_sel)) begin
                        sel_d         = bus.inlet_sel;
                        dur_load_d    = bus.dur_load;
                        period_d      = bus.pump_period;
                        cycles_d      = bus.pump_cycles;
                        dur_collect_d = bus.dur_collect;
                        cnt_d         = len_m1(bus.dur_load);
                        state_d       = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_TRANSFER;
                    cnt_d   = TRANSFER_M1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_TRANSFER: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_BEAD;
                    cnt_d   = BEAD_M1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_BEAD: begin
                if (cnt_q == 16'd0) begin
                    if (cycles_q == 16'd0) begin
                        state_d = S_COLLECT;
                        cnt_d   = len_m1(dur_collect_q);
                    end else begin
                        // steps_left counts remaining 6-step pump steps, not clocks
                        state_d      = S_PUMP;
                        step_cnt_d   = period_q;
                        step_idx_d   = 3'd0;
                        steps_left_d = ({8'd0, cycles_q} * 24'd6) - 24'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_PUMP: begin
                if (step_cnt_q == 8'd0) begin
                    if (steps_left_q == 24'd0) begin
                        state_d = S_COLLECT;
                        cnt_d   = len_m1(dur_collect_q);
                    end else begin
                        step_idx_d   = (step_idx_q == 3'd5) ? 3'd0 : step_idx_q + 3'd1;
                        step_cnt_d   = period_q;
                        steps_left_d = steps_left_q - 24'd1;
                    end
                end else begin
                    step_cnt_d = step_cnt_q - 8'd1;
                end
            end
            S_COLLECT: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q != S_IDLE) && bus.abort) begin
            state_d = S_IDLE;
        end

        // Output decode from the next state (registered below).
        inlet_ctrl_d  = 5'b11111;
        prep_inlet_d  = 1'b1;
        prep_outlet_d = 1'b1;
        stage_in_d    = 1'b1;
        stage_inlet_d = 1'b1;
        bead_d        = 1'b1;
        sieve_d       = 1'b1;
        collect_d     = 1'b1;
        pump_d        = 3'b111;
        done_d        = 1'b0;
        busy_d        = (state_d != S_IDLE);

        case (state_d)
            S_LOAD: begin
                inlet_ctrl_d = ~(5'b00001 << (sel_d - 3'd1));
                prep_inlet_d = 1'b0;
            end
            S_TRANSFER: begin
                prep_outlet_d = 1'b0;
                stage_in_d    = 1'b0;
            end
            S_BEAD: begin
                bead_d = 1'b0;
            end
            S_PUMP: begin
                pump_d = pump_pattern(step_idx_d);
            end
            S_COLLECT: begin
                collect_d = 1'b0;
                sieve_d   = 1'b0;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            step_cnt_q    <= '0;
            step_idx_q    <= '0;
            steps_left_q  <= '0;
            sel_q         <= '0;
            dur_load_q    <= '0;
            period_q      <= '0;
            cycles_q      <= '0;
            dur_collect_q <= '0;
            inlet_ctrl_q  <= 5'b11111;
            prep_inlet_q  <= 1'b1;
            prep_outlet_q <= 1'b1;
            stage_in_q    <= 1'b1;
            stage_inlet_q <= 1'b1;
            bead_q        <= 1'b1;
            sieve_q       <= 1'b1;
            collect_q     <= 1'b1;
            pump_q        <= 3'b111;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            step_cnt_q    <= step_cnt_d;
            step_idx_q    <= step_idx_d;
            steps_left_q  <= steps_left_d;
            sel_q         <= sel_d;
            dur_load_q    <= dur_load_d;
            period_q      <= period_d;
            cycles_q      <= cycles_d;
            dur_collect_q <= dur_collect_d;
            inlet_ctrl_q  <= inlet_ctrl_d;
            prep_inlet_q  <= prep_inlet_d;
            prep_outlet_q <= prep_outlet_d;
            stage_in_q    <= stage_in_d;
            stage_inlet_q <= stage_inlet_d;
            bead_q        <= bead_d;
            sieve_q       <= sieve_d;
            collect_q     <= collect_d;
            pump_q        <= pump_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bus.inlet_ctrl       = inlet_ctrl_q;
    assign bus.prep_inlet_ctrl  = prep_inlet_q;
    assign bus.prep_outlet_ctrl = prep_outlet_q;
    assign bus.stage_in_ctrl    = stage_in_q;
    assign bus.stage_inlet_ctrl = stage_inlet_q;
    assign bus.bead_ctrl        = bead_q;
    assign bus.sieve_ctrl       = sieve_q;
    assign bus.collect_ctrl     = collect_q;
    assign bus.pump1            = pump_q[2];
    assign bus.pump2            = pump_q[1];
    assign bus.pump3            = pump_q[0];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.err              = err_q;

endmodule

// File: doc/chip_valve_sequencer.md
CHIP_VALVE_SEQUENCER -- requirements
Module: chip_valve_sequencer

Interface
REQ-001 Parameters: TRANSFER_CYC, default 64, TRANSFER state length in clocks; BEAD_CYC, default 32, BEAD state length in clocks.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to run one ChIP sequence.
REQ-005 abort  input  1  terminate the run in progress.
REQ-006 inlet_sel  input  3  reagent inlet to load, legal range 1..5.
REQ-007 dur_load  input  16  LOAD length in clocks.
REQ-008 pump_period  input  8  clocks per pump step minus 1.
REQ-009 pump_cycles  input  16  number of full 6-step pump cycles.
REQ-010 dur_collect  input  16  COLLECT length in clocks.
REQ-011 inlet_ctrl  output  5  inlet valves 1..5.
REQ-012 prep_inlet_ctrl, prep_outlet_ctrl, stage_in_ctrl, stage_inlet_ctrl, bead_ctrl, sieve_ctrl, collect_ctrl  output  1 each  chamber valve controls.
REQ-013 pump1, pump2, pump3  output  1 each  peristaltic pump valves.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on sequence completion.
REQ-016 err  output  1  one-cycle pulse on an illegal start.

Function
REQ-017 All valve outputs use 1 = pressurised/closed and 0 = open; any output not listed as open for a state is 1.
REQ-018 FSM states and order: IDLE -> LOAD -> TRANSFER -> BEAD -> PUMP -> COLLECT -> DONE -> IDLE.
REQ-019 In IDLE, start with inlet_sel in 1..5 latches all duration inputs and inlet_sel and enters LOAD on the next edge.
REQ-020 In IDLE, start with inlet_sel of 0, 6 or 7 pulses err for 1 cycle, leaves the FSM in IDLE and keeps busy at 0.
REQ-021 start outside IDLE is ignored; latched parameters do not change during a run.
REQ-022 LOAD: inlet_ctrl[sel-1]=0 and prep_inlet_ctrl=0; lasts max(dur_load,1) clocks.
REQ-023 TRANSFER: prep_outlet_ctrl=0 and stage_in_ctrl=0; lasts TRANSFER_CYC clocks.
REQ-024 BEAD: bead_ctrl=0; lasts BEAD_CYC clocks.
REQ-025 PUMP: {pump1,pump2,pump3} steps through 011,001,101,100,110,010, then repeats; each step holds pump_period+1 clocks; PUMP lasts exactly pump_cycles*6*(pump_period+1) clocks.
REQ-026 pump_cycles=0: the PUMP state is skipped, so BEAD goes directly to COLLECT.
REQ-027 Outside PUMP, pump1..3 are 111; every PUMP entry starts at step 011.
REQ-028 COLLECT: collect_ctrl=0 and sieve_ctrl=0; lasts max(dur_collect,1) clocks.
REQ-029 DONE: lasts 1 clock, done=1, all valves closed.
REQ-030 Outputs are registered; an output change appears on the first clock of the state that causes it.
REQ-031 abort in any non-IDLE state: on the next edge the FSM is in IDLE, all valves and pumps are 1, and done is not pulsed.
REQ-032 abort and start in the same IDLE cycle: abort wins, and the FSM stays in IDLE.
REQ-033 State counters are 16 bits wide for state lengths and 24 bits wide for pump totals, with no wrap inside a legal run.

Reset
REQ-034 While rst_n=0: FSM=IDLE, inlet_ctrl=5'b11111, all other valve and pump outputs =1, busy=0, done=0, err=0, and counters and latched parameters are cleared.
REQ-035 Reset asserted mid-run forces the REQ-034 values immediately (asynchronously); after release the block waits for a new start.

Verification
REQ-036 Reset values: hold rst_n=0 -> all valve and pump outputs =1, busy=0; release -> outputs unchanged until start.
REQ-037 Nominal run with inlet_sel=3, dur_load=4, pump_period=1, pump_cycles=2, dur_collect=5, defaults TRANSFER_CYC=64 and BEAD_CYC=32 -> inlet_ctrl=11011 for 4 clocks, then TRANSFER 64 clocks, BEAD 32 clocks, PUMP 24 clocks with a 2-clock step pattern, COLLECT 5 clocks, done pulse at clock 130 after LOAD entry, busy high throughout.
REQ-038 Illegal start with inlet_sel=0, then inlet_sel=6 -> err pulse each time, busy=0, no valve opens.
REQ-039 abort asserted at the 3rd PUMP clock -> next clock all outputs =1, FSM in IDLE, no done pulse; a following start runs normally from step 011.
REQ-040 Edge durations: pump_cycles=0 with dur_load=0 -> LOAD lasts 1 clock, BEAD goes directly to COLLECT, done still pulses.
REQ-041 rst_n dropped during COLLECT -> collect_ctrl and sieve_ctrl return to 1 within the same cycle, busy=0.
